alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 8-bit `alu` instance between NREQ requesters using valid/ready request and response channels.
- Round-robin arbitration, one operation in flight at a time.
- Registers the operands and select lines into the ALU, waits SETTLE cycles, then captures the result and flags.
- Returns result and flags to the requester that issued the operation.
- Sits between CPU-side command sources and the `alu` datapath.

Parameters:
- NREQ, 2, number of requesters (2..4).
- SETTLE, 1, cycles that ALU inputs are held stable before capture (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester request accept; one-hot or zero.
- req_a  input  8*NREQ  operand A; slice i belongs to requester i.
- req_b  input  8*NREQ  operand B per requester.
- req_sel  input  4*NREQ  ALU_Sel code per requester.
- req_sub  input  NREQ  subtract control per requester.
- rsp_valid  output  NREQ  per-requester response valid; one-hot or zero.
- rsp_ready  input  NREQ  per-requester response accept.
- rsp_data  output  8  captured ALU result, shared by all requesters.
- rsp_flags  output  4  {carry, zero, overflow, sign}.
- rsp_err  output  1  request carried an illegal opcode.
- alu_a  output  8  registered operand A to the ALU.
- alu_b  output  8  registered operand B to the ALU.
- alu_sel  output  4  registered ALU_Sel.
- alu_sub  output  1  registered Sub.
- alu_out  input  8  ALU_Out.
- alu_carry  input  1  CarryOut.
- alu_zero  input  1  ZeroFlag.
- alu_ovf  input  1  OverflowFlag.
- alu_sign  input  1  SignFlag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset
  - One clock `clk`; reset `rst` is asynchronous and active-high.
  - On reset: state=IDLE, RR pointer=0, all outputs 0 (alu_* 0, rsp_* 0, busy 0, req_ready 0).
  - Reset mid-operation abandons the operation; no response is issued.
- Legal opcodes: 0000 add/sub, 0010 mul, 0100 shl, 0101 shr, 1000 and, 1001 or, 1010 xor, 1100 not. All other codes are illegal.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE
  - Grant g = first requester with req_valid, searching from the RR pointer upward and wrapping.
  - req_ready[g] is asserted combinationally in the same cycle. The handshake completes that cycle.
  - On the clock edge, capture req_a/b/sel/sub[g] into alu_* and store g.
  - Legal opcode: go to WAIT with counter=SETTLE-1.
  - Illegal opcode: leave alu_* unchanged. Load rsp_data=0, rsp_flags=0, rsp_err=1, and go to RESP.
- WAIT
  - Hold alu_* stable.
  - counter>0: decrement.
  - counter==0: capture rsp_data=alu_out, rsp_flags={alu_carry,alu_zero,alu_ovf,alu_sign}, rsp_err=0, and go to RESP.
- RESP
  - rsp_valid[g]=1. rsp_data, rsp_flags and rsp_err are held stable.
  - On rsp_ready[g]: clear rsp_valid, set RR pointer=(g+1) mod NREQ, go to IDLE.
  - rsp_ready on non-granted lines is ignored.
  - req_ready stays 0 in WAIT and RESP.
- Latency and throughput
  - Accept to rsp_valid is SETTLE+1 cycles for a legal opcode and 1 cycle for an illegal one.
  - Minimum spacing between accepts is SETTLE+2 cycles with rsp_ready held high.
- Fairness
  - The pointer advances only on a completed response.
  - With all requesters valid continuously, grants rotate 0,1,..,NREQ-1,0.
- Requester-side rules
  - A requester may drop req_valid before it is accepted; no ordering is guaranteed for that requester.
  - Payload changes while not granted are harmless.
- Simultaneous events: a new req_valid arriving in the same cycle as the RESP handshake is seen in the next IDLE cycle. There is no zero-bubble pass-through.

Decomposition:
- Shared package `alu_pkg`:
  - opcode localparams (OP_ADD=4'b0000, OP_MUL, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR, OP_NOT);
  - function is_legal_op;
  - state enum {IDLE, WAIT, RESP};
  - flag bit indices FLG_C=3, FLG_Z=2, FLG_V=1, FLG_S=0.
- One sub-module, `rr_picker`: combinational round-robin, taking (valid vector, pointer) and returning one-hot grant plus index.
- The bench instantiates alu_arbiter together with a real `alu`.

Test Plan:
1. Req0 A=0x7F B=0x01 sel=0000 sub=0, SETTLE=1 -> req_ready[0] in the request cycle; rsp_valid[0] 2 cycles later; data=0x80, flags=0011, err=0.
2. Req1 A=0x05 B=0x05 sel=0000 sub=1 -> data=0x00, flags=1100.
3. Req0 A=0x30 B=0x40 sel=0010 -> data=0x0C, flags=0000.
4. Both requesters valid continuously for 6 ops with rsp_ready=1 -> grants 0,1,0,1,0,1; accept spacing exactly 3 cycles.
5. Req1 sel=0111 -> no change on alu_*; rsp_valid[1] 1 cycle after accept; data=0, flags=0, err=1.
6. Hold rsp_ready=0 for 5 cycles, then assert rst mid-RESP -> rsp_valid and busy drop to 0 immediately; after release the next request is granted starting from requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and arbiter state shared by the ALU and its arbiter.
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_SHL = 4'b0100;
   localparam logic [3:0] OP_SHR = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_NOT = 4'b1100;
   localparam int FLG_C = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_S = 0;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   function automatic logic is_legal_op(input logic [3:0] op);
      return op inside {OP_ADD, OP_MUL, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR, OP_NOT};
   endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational 8-bit ALU; mul returns the high byte of the 16-bit product.
module alu
   import alu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] sel,
   input  logic       sub,
   output logic [7:0] out,
   output logic       carry,
   output logic       zero,
   output logic       ovf,
   output logic       sign
);
   logic [8:0]  s;
   logic [15:0] p;
   always_comb begin
      s = sub ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
      p = {8'h00, a} * {8'h00, b};
      out = '0;
      carry = 1'b0;
      ovf = 1'b0;
      case (sel)
         OP_ADD: begin
            out = s[7:0];
            carry = s[8];
            ovf = (a[7] == (b[7] ^ sub)) && (s[7] != a[7]);
         end
         OP_MUL: out = p[15:8];
         OP_SHL: {carry, out} = {a, 1'b0};
         OP_SHR: {out, carry} = {1'b0, a};
         OP_AND: out = a & b;
         OP_OR:  out = a | b;
         OP_XOR: out = a ^ b;
         OP_NOT: out = ~a;
         default: out = '0;
      endcase
      zero = out == 8'h00;
      sign = out[7];
   end
endmodule

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first valid requester at or above ptr, wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] j;
   always_comb begin
      idx = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (valid[j]) idx = j;
      end
      any = |valid;
      grant = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters,
// one operation in flight, operands held SETTLE cycles before the result is captured.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   input  logic [4*NREQ-1:0] req_sel,
   input  logic [NREQ-1:0]   req_sub,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [7:0]        rsp_data,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_sel,
   output logic              alu_sub,
   input  logic [7:0]        alu_out,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_ovf,
   input  logic              alu_sign,
   output logic              busy
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   state_t        state;
   logic [IW-1:0] ptr, g, idx;
   logic [NREQ-1:0] grant;
   logic          any;
   logic [3:0]    cnt;
   logic [7:0]    p_a, p_b;
   logic [3:0]    p_sel;
   logic          p_sub;
   rr_picker #(.N(NREQ), .IW(IW)) u_pick (
      .valid(req_valid),
      .ptr  (ptr),
      .grant(grant),
      .idx  (idx),
      .any  (any)
   );
   always_comb begin
      p_a = '0;
      p_b = '0;
      p_sel = '0;
      p_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == idx) begin
            p_a = req_a[8*i +: 8];
            p_b = req_b[8*i +: 8];
            p_sel = req_sel[4*i +: 4];
            p_sub = req_sub[i];
         end
      end
   end
   assign req_ready = (state == IDLE) ? grant : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         g <= '0;
         cnt <= '0;
         alu_a <= '0;
         alu_b <= '0;
         alu_sel <= '0;
         alu_sub <= 1'b0;
         rsp_valid <= '0;
         rsp_data <= '0;
         rsp_flags <= '0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               g <= idx;
               if (is_legal_op(p_sel)) begin
                  alu_a <= p_a;
                  alu_b <= p_b;
                  alu_sel <= p_sel;
                  alu_sub <= p_sub;
                  cnt <= 4'(SETTLE - 1);
                  state <= WAIT;
               end else begin
                  // illegal opcode never reaches the ALU; answer immediately with an error
                  rsp_data <= '0;
                  rsp_flags <= '0;
                  rsp_err <= 1'b1;
                  rsp_valid <= grant;
                  state <= RESP;
               end
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               rsp_data <= alu_out;
               rsp_flags[FLG_C] <= alu_carry;
               rsp_flags[FLG_Z] <= alu_zero;
               rsp_flags[FLG_V] <= alu_ovf;
               rsp_flags[FLG_S] <= alu_sign;
               rsp_err <= 1'b0;
               rsp_valid <= NREQ'(1) << g;
               state <= RESP;
            end
            RESP: if (rsp_ready[g]) begin
               rsp_valid <= '0;
               ptr <= (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of alu_arbiter driving a real alu, checked against a
// transaction-level model every cycle plus literal expectations from hand calculation.
module tb_alu_arbiter;
   import alu_pkg::*;
   localparam int NREQ = 2;
   localparam int SETTLE = 1;
   logic clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0, req_sub = '0, rsp_ready = '1, req_ready, rsp_valid;
   logic [8*NREQ-1:0] req_a = '0, req_b = '0;
   logic [4*NREQ-1:0] req_sel = '0;
   logic [7:0] rsp_data, alu_a, alu_b, alu_out;
   logic [3:0] rsp_flags, alu_sel;
   logic rsp_err, alu_sub, alu_carry, alu_zero, alu_ovf, alu_sign, busy;
   int total = 0, bad = 0, cyc = 0;
   int acc_idx[$], acc_cyc[$];
   always #5 clk = ~clk;
   alu_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_sub(req_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .alu_sub(alu_sub), .alu_out(alu_out), .alu_carry(alu_carry),
      .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_sign(alu_sign), .busy(busy)
   );
   alu u_alu (
      .a(alu_a), .b(alu_b), .sel(alu_sel), .sub(alu_sub), .out(alu_out),
      .carry(alu_carry), .zero(alu_zero), .ovf(alu_ovf), .sign(alu_sign)
   );
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask
   // returns {err, carry, zero, ovf, sign, data[7:0]}
   function automatic logic [12:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic u);
      int ua, ub, t, st;
      logic [7:0] d;
      logic c, v, e;
      ua = a; ub = b; d = 0; c = 0; v = 0; e = 0;
      case (s)
         4'b0000: begin
            t = u ? ua - ub : ua + ub;
            d = 8'(t);
            c = u ? (ua >= ub) : (t > 255);
            st = u ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
            v = st > 127 || st < -128;
         end
         4'b0010: d = 8'((ua * ub) / 256);
         4'b0100: begin d = 8'(ua * 2); c = ua >= 128; end
         4'b0101: begin d = 8'(ua / 2); c = ua % 2 == 1; end
         4'b1000: d = a & b;
         4'b1001: d = a | b;
         4'b1010: d = a ^ b;
         4'b1100: d = ~a;
         default: e = 1;
      endcase
      return e ? 13'h1000 : {1'b0, c, d == 8'h00, v, d[7], d};
   endfunction
   int m_ptr = 0, m_g = 0, m_due = 0;
   bit m_pend = 0;
   logic [12:0] m_res = '0;
   logic [20:0] m_alu = '0;
   always @(negedge clk) begin
      int pk;
      logic [NREQ-1:0] rr_exp, rv_exp;
      logic [7:0] ma, mb;
      logic [3:0] ms;
      logic mu;
      cyc++;
      if (rst) begin m_pend = 0; m_ptr = 0; m_alu = '0; end
      pk = -1;
      for (int k = NREQ - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % NREQ]) pk = (m_ptr + k) % NREQ;
      rr_exp = (!m_pend && pk >= 0) ? NREQ'(1) << pk : '0;
      rv_exp = (m_pend && m_due == 0) ? NREQ'(1) << m_g : '0;
      chk("req_ready", req_ready, rr_exp);
      chk("rsp_valid", rsp_valid, rv_exp);
      chk("busy", busy, m_pend);
      chk("alu_regs", {alu_a, alu_b, alu_sel, alu_sub}, m_alu);
      if (rv_exp != 0) chk("rsp_payload", {rsp_err, rsp_flags, rsp_data}, m_res);
      if (rst) chk("rsp_regs_rst", {rsp_err, rsp_flags, rsp_data}, 0);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin acc_idx.push_back(i); acc_cyc.push_back(cyc); end
      if (!rst) begin
         if (rv_exp != 0 && rsp_ready[m_g]) begin
            m_pend = 0;
            m_ptr = (m_g + 1) % NREQ;
         end else if (m_pend && m_due > 0) m_due--;
         else if (!m_pend && pk >= 0) begin
            ma = 8'(req_a >> (8 * pk));
            mb = 8'(req_b >> (8 * pk));
            ms = 4'(req_sel >> (4 * pk));
            mu = req_sub[pk];
            m_pend = 1;
            m_g = pk;
            m_res = ref_op(ma, mb, ms, mu);
            if (!m_res[12]) m_alu = {ma, mb, ms, mu};
            m_due = m_res[12] ? 0 : SETTLE;
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] s, input logic u);
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
      req_sel[4*i +: 4] = s;
      req_sub[i] = u;
      req_valid[i] = 1'b1;
   endtask
   task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic u, input logic [7:0] ed, input logic [3:0] ef, input logic ee,
                        input int el, input string nm);
      int n;
      set_req(i, a, b, s, u);
      #1 chk({nm, "_ready"}, req_ready, NREQ'(1) << i);
      step();
      req_valid = '0;
      n = 1;
      while (!rsp_valid[i] && n < 40) begin step(); n++; end
      chk({nm, "_lat"}, n, el);
      chk({nm, "_data"}, rsp_data, ed);
      chk({nm, "_flags"}, rsp_flags, ef);
      chk({nm, "_err"}, rsp_err, ee);
      step();
   endtask
   initial begin
      int n0, k;
      repeat (3) step();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
      rst = 1'b0;
      step();
      do_op(0, 8'h7F, 8'h01, 4'b0000, 1'b0, 8'h80, 4'b0011, 1'b0, 2, "t1_add");
      do_op(0, 8'h30, 8'h40, 4'b0010, 1'b0, 8'h0C, 4'b0000, 1'b0, 2, "t3_mul");
      do_op(1, 8'h05, 8'h05, 4'b0000, 1'b1, 8'h00, 4'b1100, 1'b0, 2, "t2_sub");
      n0 = acc_idx.size();
      set_req(0, 8'h3C, 8'h0F, 4'b1000, 1'b0);
      set_req(1, 8'h81, 8'h81, 4'b0000, 1'b0);
      k = 0;
      while (acc_idx.size() < n0 + 6 && k < 60) begin step(); k++; end
      req_valid = '0;
      chk("t4_count", acc_idx.size() - n0, 6);
      for (int i = 0; i < 6 && n0 + i < acc_idx.size(); i++) begin
         chk("t4_grant", acc_idx[n0 + i], i % 2);
         if (i > 0) chk("t4_spacing", acc_cyc[n0 + i] - acc_cyc[n0 + i - 1], SETTLE + 2);
      end
      k = 0;
      while (busy && k < 20) begin step(); k++; end
      do_op(1, 8'hAA, 8'h55, 4'b0111, 1'b1, 8'h00, 4'b0000, 1'b1, 1, "t5_ill");
      chk("t5_alu_a", alu_a, 8'h81);
      chk("t5_alu_sel", alu_sel, 4'b0000);
      do_op(0, 8'h01, 8'h02, 4'b1001, 1'b0, 8'h03, 4'b0000, 1'b0, 2, "t6_pre");
      rsp_ready = '0;
      set_req(1, 8'h10, 8'h20, 4'b0000, 1'b0);
      step();
      req_valid = '0;
      k = 0;
      while (!rsp_valid[1] && k < 40) begin step(); k++; end
      repeat (5) step();
      chk("t6_hold", rsp_valid, 2'b10);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", rsp_valid, 0);
      chk("t6_rst_busy", busy, 0);
      step();
      rst = 1'b0;
      rsp_ready = '1;
      set_req(0, 8'h0F, 8'h01, 4'b0100, 1'b0);
      set_req(1, 8'h0F, 8'h01, 4'b0101, 1'b0);
      #1 chk("t6_first", req_ready, 2'b01);
      step();
      req_valid = '0;
      k = 0;
      while (busy && k < 20) begin step(); k++; end
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
